// File: rtl/uvmt_clk_st_period_chkr.sv
// rtl/uvmt_clk_st_period_chkr.sv - multi-channel clock period / stuck checker
// Oversamples NUM_CH monitored clocks on clk, measures rise-to-rise period, flags mismatch and stuck.
module uvmt_clk_st_period_chkr #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 16,
   parameter int ERR_CNT_W   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [NUM_CH-1:0]             enable_i,
   input  logic [NUM_CH-1:0]             mon_clk_i,
   input  logic [NUM_CH*CNT_W-1:0]       exp_period_i,
   input  logic [CNT_W-1:0]              tolerance_i,
   input  logic [CNT_W-1:0]              timeout_i,
   input  logic                          clr_err_i,
   output logic [NUM_CH-1:0]             period_valid_o,
   output logic [NUM_CH*CNT_W-1:0]       period_o,
   output logic [NUM_CH-1:0]             err_pulse_o,
   output logic [NUM_CH-1:0]             err_sticky_o,
   output logic [NUM_CH-1:0]             stuck_o,
   output logic [NUM_CH*ERR_CNT_W-1:0]   err_cnt_o
);

   localparam logic [1:0] ST_DISABLED = 2'd0;
   localparam logic [1:0] ST_SYNC     = 2'd1;
   localparam logic [1:0] ST_MEASURE  = 2'd2;
   localparam logic [CNT_W-1:0]     CNT_MAX = '1;
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync_dly_q;
      logic                   rise_q;
      logic [1:0]             state_q, state_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
      logic [CNT_W-1:0]       period_q, period_d, exp_period;
      logic                   pv_q, pv_d, errp_q, errp_d;
      logic                   sticky_q, sticky_d, stuck_q, stuck_d;
      logic [ERR_CNT_W-1:0]   errcnt_q, errcnt_d, errcnt_base;
      logic [CNT_W:0]         diff;
      logic                   mismatch, timeout_hit, err;

      assign exp_period  = exp_period_i[ch*CNT_W +: CNT_W];
      assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      assign diff        = (cnt_q >= exp_period) ? ({1'b0, cnt_q} - {1'b0, exp_period})
                                                 : ({1'b0, exp_period} - {1'b0, cnt_q});
      assign mismatch    = diff > {1'b0, tolerance_i};
      assign timeout_hit = !rise_q && (timeout_i != '0) && (cnt_q == timeout_i) && !stuck_q;
      // A clear coinciding with an error still records that error
      assign errcnt_base = clr_err_i ? '0 : errcnt_q;

      always_comb begin
         state_d  = state_q;
         cnt_d    = cnt_q;
         period_d = period_q;
         pv_d     = 1'b0;
         stuck_d  = stuck_q;
         err      = 1'b0;
         if (!enable_i[ch]) begin
            state_d = ST_DISABLED;
            cnt_d   = '0;
            stuck_d = 1'b0;
         end else begin
            case (state_q)
               ST_DISABLED: begin
                  state_d = ST_SYNC;
                  cnt_d   = '0;
               end
               ST_SYNC: begin
                  if (rise_q) begin
                     state_d = ST_MEASURE;
                     cnt_d   = CNT_W'(1);
                     stuck_d = 1'b0;
                  end else begin
                     cnt_d = cnt_inc;
                     if (timeout_hit) begin
                        stuck_d = 1'b1;
                        err     = 1'b1;
                     end
                  end
               end
               ST_MEASURE: begin
                  if (rise_q) begin
                     cnt_d    = CNT_W'(1);
                     period_d = cnt_q;
                     pv_d     = 1'b1;
                     err      = mismatch;
                  end else begin
                     cnt_d = cnt_inc;
                     if (timeout_hit) begin
                        stuck_d = 1'b1;
                        err     = 1'b1;
                        state_d = ST_SYNC;
                     end
                  end
               end
               default: begin
                  state_d = ST_DISABLED;
                  cnt_d   = '0;
               end
            endcase
         end
         errp_d   = err;
         sticky_d = err | (sticky_q & ~clr_err_i);
         errcnt_d = (err && errcnt_base != ERR_MAX) ? errcnt_base + ERR_CNT_W'(1) : errcnt_base;
      end

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
            rise_q     <= 1'b0;
            state_q    <= ST_DISABLED;
            cnt_q      <= '0;
            period_q   <= '0;
            pv_q       <= 1'b0;
            errp_q     <= 1'b0;
            sticky_q   <= 1'b0;
            stuck_q    <= 1'b0;
            errcnt_q   <= '0;
         end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], mon_clk_i[ch]};
            sync_dly_q <= sync_q[SYNC_STAGES-1];
            rise_q     <= sync_q[SYNC_STAGES-1] & ~sync_dly_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            pv_q       <= pv_d;
            errp_q     <= errp_d;
            sticky_q   <= sticky_d;
            stuck_q    <= stuck_d;
            errcnt_q   <= errcnt_d;
         end
      end

      assign period_valid_o[ch]                    = pv_q;
      assign period_o[ch*CNT_W +: CNT_W]           = period_q;
      assign err_pulse_o[ch]                       = errp_q;
      assign err_sticky_o[ch]                      = sticky_q;
      assign stuck_o[ch]                           = stuck_q;
      assign err_cnt_o[ch*ERR_CNT_W +: ERR_CNT_W]  = errcnt_q;
   end

endmodule

// File: tb/tb_uvmt_clk_st_period_chkr.sv
// tb/tb_uvmt_clk_st_period_chkr.sv - randomized self-checking bench for uvmt_clk_st_period_chkr
// Edges are generated on known clk cycles; the model predicts periods, errors and their arrival cycle.
module tb_uvmt_clk_st_period_chkr;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  enable;
   logic [1:0]  mon_clk;
   logic [31:0] exp_period;
   logic [15:0] tolerance;
   logic [15:0] timeout;
   logic        clr_err;
   logic [1:0]  period_valid;
   logic [31:0] period;
   logic [1:0]  err_pulse;
   logic [1:0]  err_sticky;
   logic [1:0]  stuck;
   logic [15:0] err_cnt;

   uvmt_clk_st_period_chkr dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .enable_i       (enable),
      .mon_clk_i      (mon_clk),
      .exp_period_i   (exp_period),
      .tolerance_i    (tolerance),
      .timeout_i      (timeout),
      .clr_err_i      (clr_err),
      .period_valid_o (period_valid),
      .period_o       (period),
      .err_pulse_o    (err_pulse),
      .err_sticky_o   (err_sticky),
      .stuck_o        (stuck),
      .err_cnt_o      (err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Rising edge driven on cycle k is reported on cycle k + sync stages + 2
   localparam int LAT = 4;

   typedef struct { int per; int due; bit bad; } exp_t;
   exp_t expq[2][$];

   int errors = 0;
   int checks = 0;
   int per_a[2], per_b[2], cur_per[2], ph[2];
   bit gen_on[2];
   int last_edge[2], edge_cyc[2];
   int exp_err[2], stuck_pulses[2];
   int exp_p[2], tol_m;

   function automatic int sat8(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic bg_loop();
      forever begin
         @(negedge clk);
         for (int ch = 0; ch < 2; ch++) begin
            exp_t e;
            int   d;
            while (expq[ch].size() > 0 && expq[ch][0].due < cyc) begin
               checks++; errors++;
               $display("FAIL missing_valid ch%0d: no pulse by cycle %0d, required period %0d at cycle %0d",
                        ch, cyc, expq[ch][0].per, expq[ch][0].due);
               void'(expq[ch].pop_front());
            end
            if (period_valid[ch]) begin
               checks++;
               if (expq[ch].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_valid ch%0d: period=%0d at cycle %0d, required no pulse",
                           ch, period[ch*16 +: 16], cyc);
               end else begin
                  e = expq[ch].pop_front();
                  if (period[ch*16 +: 16] !== 16'(e.per) || cyc != e.due || err_pulse[ch] !== e.bad) begin
                     errors++;
                     $display("FAIL period_check ch%0d: period=%0d cyc=%0d err=%b, required %0d/%0d/%b",
                              ch, period[ch*16 +: 16], cyc, err_pulse[ch], e.per, e.due, e.bad);
                  end
               end
            end else if (err_pulse[ch]) begin
               stuck_pulses[ch]++;
            end
            if (!gen_on[ch]) begin
               mon_clk[ch] = 1'b0;
               ph[ch] = 0;
            end else begin
               if (ph[ch] == 0) begin
                  cur_per[ch] = ($urandom & 1) ? per_a[ch] : per_b[ch];
                  mon_clk[ch] = 1'b1;
                  edge_cyc[ch] = cyc;
                  if (last_edge[ch] >= 0) begin
                     d = cyc - last_edge[ch];
                     e.per = d;
                     e.due = cyc + LAT;
                     e.bad = ((d > exp_p[ch]) ? d - exp_p[ch] : exp_p[ch] - d) > tol_m;
                     if (e.bad) exp_err[ch]++;
                     expq[ch].push_back(e);
                  end
                  last_edge[ch] = cyc;
               end else if (ph[ch] == cur_per[ch] / 2) begin
                  mon_clk[ch] = 1'b0;
               end
               ph[ch] = (ph[ch] + 1 >= cur_per[ch]) ? 0 : ph[ch] + 1;
            end
         end
      end
   endtask

   task automatic setup(input int a0, input int b0, input int a1, input int b1,
                        input int e0, input int e1, input int tol, input int to);
      gen_on[0] = 0; gen_on[1] = 0;
      repeat (8) @(negedge clk);
      enable = 2'b00;
      repeat (2) @(negedge clk);
      exp_period = {e1[15:0], e0[15:0]};
      tolerance = tol[15:0];
      timeout = to[15:0];
      exp_p[0] = e0; exp_p[1] = e1; tol_m = tol;
      per_a[0] = a0; per_b[0] = b0; per_a[1] = a1; per_b[1] = b1;
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
         exp_err[ch] = 0; stuck_pulses[ch] = 0; last_edge[ch] = -1;
         expq[ch].delete();
      end
      enable = 2'b11;
      repeat (4) @(negedge clk);
      gen_on[0] = 1; gen_on[1] = 1;
   endtask

   task automatic stop_and_check(input string name);
      gen_on[0] = 0; gen_on[1] = 0;
      repeat (8) @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
         checks++;
         if (err_cnt[ch*8 +: 8] !== 8'(sat8(exp_err[ch] + stuck_pulses[ch])) || expq[ch].size() != 0) begin
            errors++;
            $display("FAIL %s_errcnt ch%0d: err_cnt=%0d pending=%0d, required %0d pending=0",
                     name, ch, err_cnt[ch*8 +: 8], expq[ch].size(), sat8(exp_err[ch] + stuck_pulses[ch]));
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 2'b00; mon_clk = 2'b00; clr_err = 1'b0;
      exp_period = '0; tolerance = '0; timeout = '0;
      repeat (3) @(negedge clk);
      checks++; if (period_valid !== 2'b0) begin errors++; $display("FAIL reset_valid: %b required 00", period_valid); end
      checks++; if (period !== 32'b0) begin errors++; $display("FAIL reset_period: %h required 0", period); end
      checks++; if (err_pulse !== 2'b0) begin errors++; $display("FAIL reset_errpulse: %b required 00", err_pulse); end
      checks++; if (err_sticky !== 2'b0) begin errors++; $display("FAIL reset_sticky: %b required 00", err_sticky); end
      checks++; if (stuck !== 2'b0) begin errors++; $display("FAIL reset_stuck: %b required 00", stuck); end
      checks++; if (err_cnt !== 16'b0) begin errors++; $display("FAIL reset_errcnt: %h required 0", err_cnt); end
      reset = 1'b0;
   endtask

   task automatic test_nominal();
      setup(10, 10, 10, 11, 10, 10, 0, 0);
      repeat (300) @(negedge clk);
      checks++;
      if (period[15:0] !== 16'd10 || err_sticky[0] !== 1'b0) begin
         errors++;
         $display("FAIL nominal_ch0: period=%0d sticky=%b, required 10/0", period[15:0], err_sticky[0]);
      end
      stop_and_check("nominal");
   endtask

   task automatic test_saturate();
      setup(12, 12, 11, 11, 10, 10, 1, 0);
      repeat (300 * 12 + 20) @(negedge clk);
      stop_and_check("saturate");
      checks++;
      if (err_cnt[7:0] !== 8'd255 || err_cnt[15:8] !== 8'd0 || err_sticky !== 2'b01) begin
         errors++;
         $display("FAIL saturate_final: cnt0=%0d cnt1=%0d sticky=%b, required 255/0/01",
                  err_cnt[7:0], err_cnt[15:8], err_sticky);
      end
   endtask

   task automatic test_jitter();
      setup(9, 12, 9, 13, 10, 10, 2, 0);
      repeat (1500) @(negedge clk);
      stop_and_check("jitter");
   endtask

   task automatic test_timeout();
      bit found;
      int stop_edge;
      setup(10, 10, 10, 10, 10, 10, 0, 32);
      repeat (100) @(negedge clk);
      gen_on[0] = 0;
      found = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (stuck[0]) begin found = 1; break; end
      end
      checks++;
      if (!found || cyc != edge_cyc[0] + LAT + 32) begin
         errors++;
         $display("FAIL stuck_set: found=%b cycle=%0d, required cycle %0d", found, cyc, edge_cyc[0] + LAT + 32);
      end
      repeat (100) @(negedge clk);
      checks++;
      if (err_cnt[7:0] !== 8'd1 || stuck_pulses[0] != 1 || stuck !== 2'b01 || err_sticky !== 2'b01) begin
         errors++;
         $display("FAIL stuck_once: cnt=%0d pulses=%0d stuck=%b sticky=%b, required 1/1/01/01",
                  err_cnt[7:0], stuck_pulses[0], stuck, err_sticky);
      end
      stop_edge = edge_cyc[0];
      last_edge[0] = -1;
      gen_on[0] = 1;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!stuck[0]) begin found = 1; break; end
      end
      checks++;
      if (!found || edge_cyc[0] == stop_edge || cyc != edge_cyc[0] + LAT) begin
         errors++;
         $display("FAIL stuck_clear: found=%b cycle=%0d, required cycle %0d", found, cyc, edge_cyc[0] + LAT);
      end
      repeat (60) @(negedge clk);
      checks++;
      if (stuck_pulses[0] != 1 || period[15:0] !== 16'd10 || stuck !== 2'b00) begin
         errors++;
         $display("FAIL stuck_recover: pulses=%0d period=%0d stuck=%b, required 1/10/00",
                  stuck_pulses[0], period[15:0], stuck);
      end
      for (int ch = 0; ch < 2; ch++) begin
         checks++;
         if (err_cnt[ch*8 +: 8] !== 8'(exp_err[ch] + stuck_pulses[ch])) begin
            errors++;
            $display("FAIL timeout_errcnt ch%0d: %0d required %0d", ch, err_cnt[ch*8 +: 8], exp_err[ch] + stuck_pulses[ch]);
         end
      end
   endtask

   task automatic test_clr_collision();
      bit found;
      setup(12, 12, 10, 10, 10, 10, 0, 0);
      repeat (50) @(negedge clk);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cyc == edge_cyc[0] + LAT - 1) begin found = 1; break; end
      end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      checks++;
      if (!found || err_pulse[0] !== 1'b1 || err_sticky[0] !== 1'b1 || err_cnt[7:0] !== 8'd1) begin
         errors++;
         $display("FAIL clr_collide_ch0: found=%b pulse=%b sticky=%b cnt=%0d, required 1/1/1/1",
                  found, err_pulse[0], err_sticky[0], err_cnt[7:0]);
      end
      checks++;
      if (err_sticky[1] !== 1'b0 || err_cnt[15:8] !== 8'd0) begin
         errors++;
         $display("FAIL clr_collide_ch1: sticky=%b cnt=%0d, required 0/0", err_sticky[1], err_cnt[15:8]);
      end
      gen_on[0] = 0; gen_on[1] = 0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_and_enable();
      bit found;
      logic [7:0] kept;
      setup(12, 12, 12, 12, 10, 12, 0, 0);
      repeat (100) @(negedge clk);
      found = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (cyc == edge_cyc[0] + LAT + 4) begin found = 1; break; end
      end
      reset = 1'b1;
      for (int ch = 0; ch < 2; ch++) begin
         exp_err[ch] = 0; stuck_pulses[ch] = 0; last_edge[ch] = -1;
         expq[ch].delete();
      end
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (!found || period_valid !== 2'b0 || period !== 32'b0 || err_sticky !== 2'b0 ||
          err_cnt !== 16'b0 || stuck !== 2'b0 || err_pulse !== 2'b0) begin
         errors++;
         $display("FAIL reset_mid: found=%b pv=%b period=%h sticky=%b cnt=%h, required all 0",
                  found, period_valid, period, err_sticky, err_cnt);
      end
      repeat (80) @(negedge clk);
      found = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (cyc == edge_cyc[0] + LAT + 1) begin found = 1; break; end
      end
      enable[0] = 1'b0;
      last_edge[0] = -1;
      kept = 8'(sat8(exp_err[0]));
      @(negedge clk);
      checks++;
      if (!found || kept == 8'd0 || err_cnt[7:0] !== kept || err_sticky[0] !== 1'b1 ||
          period[15:0] !== 16'd12 || stuck[0] !== 1'b0) begin
         errors++;
         $display("FAIL disable_retain: found=%b cnt=%0d sticky=%b period=%0d, required %0d (nonzero)/1/12",
                  found, err_cnt[7:0], err_sticky[0], period[15:0], kept);
      end
      enable[0] = 1'b1;
      repeat (80) @(negedge clk);
      stop_and_check("reenable");
   endtask

   initial begin
      for (int ch = 0; ch < 2; ch++) begin
         gen_on[ch] = 0; ph[ch] = 0; last_edge[ch] = -1; edge_cyc[ch] = 0;
         exp_err[ch] = 0; stuck_pulses[ch] = 0; per_a[ch] = 10; per_b[ch] = 10;
         cur_per[ch] = 10; exp_p[ch] = 10;
      end
      tol_m = 0;
      test_reset();
      fork
         bg_loop();
      join_none
      test_nominal();
      test_saturate();
      test_jitter();
      test_timeout();
      test_clr_collision();
      test_reset_and_enable();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
